// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS waveform generator producing an 8-bit offset-binary DAC
// stream (mid-scale 128) with per-period sync. Settings loaded while running
// are held pending and applied at the next phase wrap.
module dds_wave_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned CLK_FS  = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         amp,
  input  logic [7:0]         duty,
  input  logic               param_load,
  output logic               param_busy,
  output logic [7:0]         dac_data,
  output logic               sync_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  // CLK_FS is informational: f_out = freq_word * CLK_FS / 2^PHASE_W
  if (CLK_FS == 0) begin : g_clk_fs_unset
  end

  // Quarter-wave sine magnitude: round(127*sin(pi/2*(i+0.5)/64))
  localparam logic [6:0] SINE_ROM [0:63] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [1:0]         state;
  logic [PHASE_W-1:0] phase;
  logic               first;
  logic [PHASE_W-1:0] fw_act,   fw_pend;
  logic [1:0]         wave_act, wave_pend;
  logic [7:0]         amp_act,  amp_pend;
  logic [7:0]         duty_act, duty_pend;

  logic [PHASE_W-1:0] phase_sum;
  logic               wrap;

  logic [7:0]         k;
  logic [5:0]         rom_idx;
  logic [6:0]         mag;
  logic [7:0]         raw_next;

  logic [7:0]         raw1;
  logic [7:0]         amp1;
  logic               sync1;
  logic signed [8:0]  s1;
  logic signed [16:0] prod2;
  logic               sync2;

  assign param_busy = (state == PEND);

  // Phase increment; the adder carry is the period wrap
  always_comb begin
    {wrap, phase_sum} = {1'b0, phase} + {1'b0, fw_act};
  end

  // Control: phase accumulator, first-sample flag and active/pending settings.
  // Dropping run and sitting in IDLE share one path: both zero the phase and
  // apply settings at once, so a load never waits while the generator is off.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      first     <= 1'b0;
      fw_act    <= '0;
      wave_act  <= '0;
      amp_act   <= '0;
      duty_act  <= '0;
      fw_pend   <= '0;
      wave_pend <= '0;
      amp_pend  <= '0;
      duty_pend <= '0;
    end else if (!run || state == IDLE) begin
      if (param_load) begin
        fw_act   <= freq_word;
        wave_act <= wave_sel;
        amp_act  <= amp;
        duty_act <= duty;
      end else if (state == PEND) begin
        fw_act   <= fw_pend;
        wave_act <= wave_pend;
        amp_act  <= amp_pend;
        duty_act <= duty_pend;
      end
      phase <= '0;
      first <= run;
      state <= run ? RUN : IDLE;
    end else begin
      phase <= phase_sum;
      first <= wrap;
      if (param_load) begin
        if (wrap) begin
          fw_act   <= freq_word;
          wave_act <= wave_sel;
          amp_act  <= amp;
          duty_act <= duty;
          state    <= RUN;
        end else begin
          fw_pend   <= freq_word;
          wave_pend <= wave_sel;
          amp_pend  <= amp;
          duty_pend <= duty;
          state     <= PEND;
        end
      end else if (state == PEND && (wrap || fw_act == '0)) begin
        fw_act   <= fw_pend;
        wave_act <= wave_pend;
        amp_act  <= amp_pend;
        duty_act <= duty_pend;
        state    <= RUN;
      end
    end
  end

  // Raw waveform sample from the top 8 phase bits
  always_comb begin
    k        = phase[PHASE_W-1 -: 8];
    rom_idx  = k[6] ? (6'd63 - k[5:0]) : k[5:0];
    mag      = SINE_ROM[rom_idx];
    raw_next = k;
    unique case (wave_sel_dummy(wave_act))
      2'd0: raw_next = k[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
      2'd1: raw_next = (k < duty_act) ? 8'hFF : 8'h00;
      2'd2: raw_next = k[7] ? (8'd255 - {k[6:0], 1'b0}) : {k[6:0], 1'b0};
      2'd3: raw_next = k;
    endcase
  end

  function automatic logic [1:0] wave_sel_dummy(input logic [1:0] w);
    return w;
  endfunction

  // Stage 1: raw sample plus the amplitude it must be scaled with
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      raw1  <= 8'd128;
      amp1  <= '0;
      sync1 <= 1'b0;
    end else if (!run) begin
      raw1  <= 8'd128;
      amp1  <= '0;
      sync1 <= 1'b0;
    end else begin
      raw1  <= (state == IDLE) ? 8'd128 : raw_next;
      amp1  <= amp_act;
      sync1 <= (state != IDLE) && first;
    end
  end

  // Signed offset of the raw sample from mid-scale
  always_comb begin
    s1 = $signed({1'b0, raw1} - 9'd128);
  end

  // Stage 2: signed product s * amp
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prod2 <= '0;
      sync2 <= 1'b0;
    end else if (!run) begin
      prod2 <= '0;
      sync2 <= 1'b0;
    end else begin
      prod2 <= $signed(17'(s1)) * $signed(17'({1'b0, amp1}));
      sync2 <= sync1;
    end
  end

  // Stage 3: floor-scaled output back to offset binary
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data <= 8'd128;
      sync_out <= 1'b0;
    end else if (!run) begin
      dac_data <= 8'd128;
      sync_out <= 1'b0;
    end else begin
      dac_data <= 8'd128 + 8'(prod2 >>> 8);
      sync_out <= sync2;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed stimulus with a per-cycle reference model of the
// generator's observable behaviour, plus literal sample expectations.
module tb_dds_wave_gen;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] freq_word = '0;
  logic [1:0]  wave_sel = '0;
  logic [7:0]  amp = '0;
  logic [7:0]  duty = '0;
  logic        param_load = 1'b0;
  logic        param_busy;
  logic [7:0]  dac_data;
  logic        sync_out;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  int cap [0:299];
  bit capsync [0:299];

  dds_wave_gen #(.PHASE_W(32), .CLK_FS(50_000_000)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .run(run), .freq_word(freq_word),
    .wave_sel(wave_sel), .amp(amp), .duty(duty), .param_load(param_load),
    .param_busy(param_busy), .dac_data(dac_data), .sync_out(sync_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sine_mag(input int i);
    real a;
    a = 127.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 128.0);
    return int'($floor(a + 0.5));
  endfunction

  function automatic int raw_of(input int w, input int k, input int d);
    int q, i, m;
    case (w)
      0: begin
        q = k / 64;
        i = k % 64;
        m = (q % 2 == 0) ? sine_mag(i) : sine_mag(63 - i);
        return (q < 2) ? 128 + m : 128 - m;
      end
      1: return (k < d) ? 255 : 0;
      2: return (k < 128) ? 2 * k : 511 - 2 * k;
      default: return k;
    endcase
  endfunction

  function automatic int scale(input int raw, input int a);
    return 128 + int'($floor(real'((raw - 128) * a) / 256.0));
  endfunction

  bit     m_run = 0, m_pend = 0, m_first = 0, m_wrap = 0;
  longint m_phase = 0, m_sum = 0;
  longint a_fw = 0, p_fw = 0;
  int     a_w = 0, a_amp = 0, a_duty = 0, p_w = 0, p_amp = 0, p_duty = 0;
  int     pd [3] = '{128, 128, 128};
  bit     ps [3] = '{0, 0, 0};

  task automatic take_inputs();
    a_fw = longint'(freq_word); a_w = int'(wave_sel); a_amp = int'(amp); a_duty = int'(duty);
  endtask

  task automatic take_pending();
    a_fw = p_fw; a_w = p_w; a_amp = p_amp; a_duty = p_duty;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_first = 0; m_phase = 0;
      a_fw = 0; a_w = 0; a_amp = 0; a_duty = 0;
      p_fw = 0; p_w = 0; p_amp = 0; p_duty = 0;
      for (int j = 0; j < 3; j++) begin pd[j] = 128; ps[j] = 0; end
      return;
    end
    // output side: three samples in flight, cleared when run is low
    if (!run) begin
      for (int j = 0; j < 3; j++) begin pd[j] = 128; ps[j] = 0; end
    end else begin
      pd[2] = pd[1]; ps[2] = ps[1];
      pd[1] = pd[0]; ps[1] = ps[0];
      pd[0] = m_run ? scale(raw_of(a_w, int'(m_phase >> 24), a_duty), a_amp) : 128;
      ps[0] = m_run && m_first;
    end
    // settings and phase
    m_sum  = m_phase + a_fw;
    m_wrap = (m_sum >= 64'h1_0000_0000);
    if (!run || !m_run) begin
      if (param_load) take_inputs();
      else if (m_pend) take_pending();
      m_pend = 0; m_phase = 0; m_first = run; m_run = run;
    end else begin
      m_phase = m_sum & 64'hFFFF_FFFF;
      m_first = m_wrap;
      if (param_load) begin
        if (m_wrap) begin
          take_inputs(); m_pend = 0;
        end else begin
          p_fw = longint'(freq_word); p_w = int'(wave_sel); p_amp = int'(amp); p_duty = int'(duty);
          m_pend = 1;
        end
      end else if (m_pend && (m_wrap || a_fw == 0)) begin
        take_pending(); m_pend = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge sys_clk or negedge rst_n);
      model_step();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("model_dac", longint'(dac_data), longint'(pd[2]));
      chk("model_sync", longint'(sync_out), longint'(ps[2]));
      chk("model_busy", longint'(param_busy), longint'(m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic load(input int w, input longint fw, input int a, input int d);
    wave_sel = 2'(w); freq_word = 32'(fw); amp = 8'(a); duty = 8'(d);
    param_load = 1'b1;
    @(negedge sys_clk);
    param_load = 1'b0;
  endtask

  task automatic grab(input int n);
    int t = 0;
    @(negedge sys_clk);
    while (!sync_out && t < 600) begin
      @(negedge sys_clk);
      t++;
    end
    chk("sync_seen", longint'(sync_out), 1);
    for (int j = 0; j < n; j++) begin
      cap[j] = int'(dac_data);
      capsync[j] = sync_out;
      if (j < n - 1) @(negedge sys_clk);
    end
  endtask

  initial begin
    cyc(4);
    rst_n = 1'b1;
    chk_on = 1'b1;
    cyc(10);
    chk("idle_dac", longint'(dac_data), 128);
    chk("idle_sync", longint'(sync_out), 0);
    chk("idle_busy", longint'(param_busy), 0);

    // sawtooth, loaded while idle
    load(3, 64'h0100_0000, 255, 0);
    chk("idle_load_busy", longint'(param_busy), 0);
    run = 1'b1;
    grab(257);
    chk("saw_k0", cap[0], 0);
    chk("saw_k1", cap[1], 1);
    chk("saw_k128", cap[128], 128);
    chk("saw_k129", cap[129], 128);
    chk("saw_k255", cap[255], 254);
    chk("saw_next_k0", cap[256], 0);
    chk("saw_sync_period", longint'(capsync[256]), 1);
    chk("saw_no_early_sync", longint'(capsync[255]), 0);

    // sine, loaded mid-period
    load(0, 64'h0100_0000, 255, 0);
    chk("sine_load_busy", longint'(param_busy), 1);
    grab(257);
    chk("sine_k0", cap[0], 129);
    chk("sine_k63", cap[63], 254);
    chk("sine_k64", cap[64], 254);
    chk("sine_k127", cap[127], 129);
    chk("sine_k128", cap[128], 126);
    chk("sine_k191", cap[191], 1);
    chk("sine_k192", cap[192], 1);
    chk("sine_busy_done", longint'(param_busy), 0);

    // square duty 64
    load(1, 64'h0100_0000, 255, 64);
    grab(256);
    chk("sq_k0", cap[0], 254);
    chk("sq_k63", cap[63], 254);
    chk("sq_k64", cap[64], 0);
    chk("sq_k255", cap[255], 0);

    // saw then two loads while busy: only the second applies
    load(3, 64'h0100_0000, 255, 0);
    cyc(300);
    load(1, 64'h0100_0000, 255, 128);
    chk("dbl_busy1", longint'(param_busy), 1);
    cyc(5);
    load(1, 64'h0100_0000, 255, 200);
    chk("dbl_busy2", longint'(param_busy), 1);
    grab(201);
    chk("dbl_k0", cap[0], 254);
    chk("dbl_k199", cap[199], 254);
    chk("dbl_k200", cap[200], 0);

    // run drop with a pending triangle load
    load(2, 64'h0100_0000, 128, 0);
    chk("drop_busy_before", longint'(param_busy), 1);
    run = 1'b0;
    @(negedge sys_clk);
    chk("drop_dac", longint'(dac_data), 128);
    chk("drop_busy", longint'(param_busy), 0);
    chk("drop_sync", longint'(sync_out), 0);
    cyc(5);
    run = 1'b1;
    grab(129);
    chk("tri_k0", cap[0], 64);
    chk("tri_k64", cap[64], 128);
    chk("tri_k127", cap[127], 191);
    chk("tri_k128", cap[128], 191);

    // amp = 0
    load(3, 64'h0100_0000, 0, 0);
    grab(256);
    chk("amp0_k0", cap[0], 128);
    chk("amp0_k100", cap[100], 128);
    chk("amp0_k255", cap[255], 128);

    // freq_word = 0: phase stalls, next load applies one cycle later
    load(3, 0, 255, 0);
    cyc(300);
    chk("fw0_hold", longint'(dac_data), 0);
    load(1, 64'h0200_0000, 255, 64);
    chk("fw0_pend", longint'(param_busy), 1);
    cyc(1);
    chk("fw0_apply", longint'(param_busy), 0);
    cyc(200);

    // assorted frequencies for the model
    load(0, 64'h0123_4567, 200, 0);
    cyc(700);
    load(1, 64'h0A00_0001, 77, 90);
    cyc(300);
    load(2, 64'hF000_0000, 255, 0);
    cyc(100);

    // asynchronous reset mid-cycle
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_dac", longint'(dac_data), 128);
    chk("areset_sync", longint'(sync_out), 0);
    chk("areset_busy", longint'(param_busy), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Direct-digital-synthesis waveform generator for the scope/signal-generator design. It is the output-side counterpart of the ADC parameter-measurement path: it produces an 8-bit offset-binary sample stream (mid-scale 128) for the board DAC, and that stream can be looped back into the measurement path. Frequency, waveform, amplitude and duty are supplied by the Nios II register interface. New settings take effect glitch-free at the next waveform period boundary. A per-period sync pulse is provided as a trigger.

## Interface
- PHASE_W, 32, phase accumulator width; lookup index is phase[PHASE_W-1 -: 8].
- CLK_FS, 50_000_000, sys_clk frequency in Hz; documentation only; f_out = freq_word * CLK_FS / 2^PHASE_W.
- sys_clk  in  1  system/DAC sample clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  generator enable (level).
- freq_word  in  PHASE_W  phase increment (shadow input).
- wave_sel  in  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth (shadow input).
- amp  in  8  amplitude scale, 0..255 (shadow input).
- duty  in  8  square-wave high threshold (shadow input).
- param_load  in  1  one-cycle strobe; captures the four shadow inputs.
- param_busy  out  1  high while a captured load has not yet been applied.
- dac_data  out  8  registered DAC sample.
- sync_out  out  1  one-cycle pulse marking the first sample of each period.

## Operation
- States: IDLE (run=0), RUN, PEND (run=1 and a load is pending).
- Reset values: all active and pending registers 0, phase 0, pipeline raw stages 128; dac_data=8'd128, sync_out=0, param_busy=0, state IDLE.
- IDLE:
  - phase held at 0; dac_data driven 128.
  - param_load applies immediately to the active registers; param_busy stays 0.
  - run=1 moves to RUN.
- RUN: each cycle, phase <= phase + fw_act. The wrap event is the carry out of the adder.
- param_load in RUN:
  - Capture all four inputs into pending registers; param_busy=1; go to PEND.
- PEND:
  - Pending values are copied to the active registers in the cycle wrap=1.
  - The new freq_word is used from the next increment; param_busy=0; back to RUN.
  - param_load in PEND overwrites the pending values; param_busy remains 1.
- Simultaneous param_load and wrap: the just-captured values are applied at that wrap, with no extra wait.
- fw_act=0 while a load is pending: apply at the next cycle, because the accumulator can never wrap.
- run falling in RUN/PEND:
  - Any pending values are applied immediately and param_busy clears.
  - Phase resets to 0 and state goes to IDLE.
  - The pipeline is flushed: dac_data=128 from the next edge, and no sync_out pulse is issued.
- Raw sample from k = phase[31:24]:
  - Sine: q=k[7:6], i=k[5:0]. mag=ROM[i] for q even, ROM[63-i] for q odd, where ROM[i]=round(127*sin(pi/2*(i+0.5)/64)). raw = 128+mag for q<2, 128-mag otherwise.
  - Square: raw = 255 if k < duty_act, else 0. duty=0 gives a constant 0.
  - Triangle: raw = 2k for k<128, else 511-2k.
  - Sawtooth: raw = k.
- Scaling:
  - s = raw-128 (signed 9 bit).
  - p = s*amp (signed 17 bit).
  - dac_data = 128 + (p >>> 8), using an arithmetic (floor) shift.
  - Result range is 0..255 with no overflow possible. amp=0 gives a constant 128.

## Timing
- Pipeline of 3 stages: phase register → raw register (ROM/compute) → product register → dac_data register.
- A phase value present at cycle n appears on dac_data at cycle n+3.
- sync_out is asserted in the same cycle that dac_data shows the first sample computed from the post-wrap phase, i.e. 3 cycles after the wrap cycle.
- After run rises:
  - The first sample (phase 0) appears on dac_data 3 cycles later.
  - sync_out pulses with that first sample.
- Waveform/amp/duty changes become visible on dac_data 3 cycles after the apply cycle. No sample ever mixes old and new settings.
- Reset may be asserted at any time: outputs return to their reset values immediately (asynchronous reset).

## Test plan
- Reset, then release with run=0 → dac_data=128, sync_out=0, param_busy=0 indefinitely.
- Sawtooth, freq_word=2^24, amp=255, run=1:
  - Output samples are floor((k-128)*255/256)+128 for k=0..255, giving 0,1,...,254.
  - sync_out pulses every 256 cycles, coincident with the sample value 0.
- Sine, freq_word=2^24, amp=255:
  - Period 256 cycles.
  - Samples 63/64 have maximum 254; samples 191/192 have minimum 1.
  - Sample at k=0 is 129.
- Square, duty=64, amp=255, freq_word=2^24 → 64 samples of 254 then 192 samples of 0 per period.
- Send param_load with wave_sel=3→1 mid-period:
  - param_busy stays high until the wrap, then falls.
  - Waveform switches exactly at the sync_out sample.
  - A second load while busy is applied instead of the first.
- Deassert run mid-period with a load pending:
  - Next-cycle dac_data=128 and param_busy=0.
  - On re-enable, the output restarts at phase 0 with the new settings.
  - amp=0 gives a constant 128.
